// File: rtl/key_pkg.sv
// Shared constants and types for the 9-key debounce front end that feeds
// the 9-input active-low priority encoder.
package key_pkg;

  localparam int NUM_KEYS = 9;
  localparam logic KEY_IDLE = 1'b1;

  localparam int DEBOUNCE_CYCLES_SIM     = 16;
  localparam int DEBOUNCE_CYCLES_SILICON = 1_000_000;

  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_PRESS   = 2'd1,
    EV_RELEASE = 2'd2
  } key_event_e;

  function automatic logic all_idle(input logic [NUM_KEYS-1:0] keys_n);
    return &keys_n;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-line conditioner: two-flop synchroniser, consecutive-mismatch
// counter, accepted-level flop and one-clock press/release strobes.
module debounce_bit
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in_n,
  output logic stable_n,
  output logic stable_n_next,
  output logic press,
  output logic release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             ff1_q, ff1_d;
  logic             s_q, s_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  key_event_e       ev;

  always_comb begin
    ff1_d    = key_in_n;
    s_d      = ff1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    ev       = EV_NONE;
    // Any agreement with the accepted level wipes the count: no partial credit.
    if (s_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s_q;
        ev       = (s_q == KEY_IDLE) ? EV_RELEASE : EV_PRESS;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d   = (ev == EV_PRESS);
    release_d = (ev == EV_RELEASE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1_q     <= KEY_IDLE;
      s_q       <= KEY_IDLE;
      stable_q  <= KEY_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      ff1_q     <= ff1_d;
      s_q       <= s_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign stable_n      = stable_q;
  assign stable_n_next = stable_d;
  assign press         = press_q;
  assign release_o     = release_q;

endmodule

// File: rtl/key_debounce_9.sv
// Nine independent debounced key lines plus a registered any-key flag.
// The release strobe port is release_o because "release" is a reserved word.
module key_debounce_9
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in_n,
  output logic [NUM_KEYS-1:0] I_n,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] release_o,
  output logic                any_pressed
);

  logic [NUM_KEYS-1:0] i_n_next;
  logic                any_pressed_q, any_pressed_d;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk          (clk),
        .rst          (rst),
        .key_in_n     (key_in_n[gi]),
        .stable_n     (I_n[gi]),
        .stable_n_next(i_n_next[gi]),
        .press        (press[gi]),
        .release_o    (release_o[gi])
      );
    end
  endgenerate

  // Built from the next-state vector so the flag lands in the same cycle as I_n.
  always_comb begin
    any_pressed_d = ~all_idle(i_n_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_pressed_q <= 1'b0;
    end else begin
      any_pressed_q <= any_pressed_d;
    end
  end

  assign any_pressed = any_pressed_q;

endmodule
